wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 5: number of functional-unit requesters.
REQ-002 Parameter DATA_WIDTH, default 32: result width.
REQ-003 Parameter ROB_SIZE, default 4: ROB tag width.
REQ-004 Parameter DEST_REG_SIZE, default 3: destination register width.
REQ-005 Parameter CTRL_WIDTH, default 6: control field width.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 req_valid  in  NUM_FU  per-unit result-ready request.
REQ-009 req_data  in  NUM_FU*DATA_WIDTH  packed results; unit i occupies slice i.
REQ-010 req_rob  in  NUM_FU*ROB_SIZE  packed ROB tags.
REQ-011 req_dest  in  NUM_FU*DEST_REG_SIZE  packed destination registers.
REQ-012 req_ctrl  in  NUM_FU*CTRL_WIDTH  packed control fields.
REQ-013 flush  in  1  discard the held output entry.
REQ-014 out_ready  in  1  downstream writeback accepts the output this cycle.
REQ-015 grant  out  NUM_FU  one-hot, combinational; unit i's request is captured this cycle.
REQ-016 out_valid, out_data, out_rob, out_dest, out_ctrl  out  1/DATA_WIDTH/ROB_SIZE/DEST_REG_SIZE/CTRL_WIDTH  registered winner.
REQ-017 out_nop  out  1  equals ~out_valid.

Function
REQ-018 A requester holds req_valid and its payload stable until it sees grant; the arbiter never drops a granted payload.
REQ-019 The output register is free when out_valid=0 or out_ready=1, and flush=0.
REQ-020 grant is non-zero only when the output register is free and at least one req_valid bit is set; at most one bit is set.
REQ-021 On a grant to unit i, the output register loads unit i's payload at the next edge with out_valid=1: request-to-output latency is 1 cycle.
REQ-022 If out_valid=1 and out_ready=0, the output holds all fields stable and grant is 0.
REQ-023 If out_ready=1 and there is no grant, out_valid clears at the next edge.
REQ-024 Back-to-back: with continuous requests and out_ready=1, one result is delivered per cycle.
REQ-025 flush=1 forces grant to 0 and clears out_valid at the next edge, overriding out_ready.
REQ-026 Flush does not change the priority pointer; pending requests are re-arbitrated after flush deasserts.
REQ-027 The perf counter stall_cnt (16 bits, internal) increments each cycle that any req_valid=1 and grant=0.
REQ-028 stall_cnt saturates at 16'hFFFF.
REQ-029 Unused payload fields while out_valid=0 are don't-care, but the bench checks that they are X-free after reset.

Reset
REQ-030 At reset: out_valid=0; out_data, out_rob, out_dest and out_ctrl are 0; out_nop=1; grant=0; priority pointer=0; stall_cnt=0.
REQ-031 Reset mid-transfer discards the held entry; a requester that was not granted keeps its request.

Configuration
REQ-032 With WB_RR_EN defined, selection is round-robin.
  - Search starts at index ptr and wraps modulo NUM_FU.
  - On a grant to unit i, ptr becomes (i+1) mod NUM_FU, so NUM_FU-1 wraps to 0.
REQ-033 Without WB_RR_EN, selection is fixed priority, lowest index wins, and ptr stays constant at 0.

Structure
REQ-034 A shared package wb_pkg holds the default widths, the NUM_FU default and the payload struct typedef (data, rob, dest, ctrl).
REQ-035 One sub-module, wb_rr_pick, is a combinational one-hot picker (request vector, start pointer -> grant); it is instantiated once.

Verification
REQ-036 Reset, then idle -> out_valid=0, out_nop=1, grant=5'b00000.
REQ-037 req_valid=5'b00100 with data 32'hDEAD_0002 and rob 4'h7; out_ready=1 -> grant=5'b00100 in cycle 0; cycle 1: out_valid=1, out_data=32'hDEAD_0002, out_rob=4'h7.
REQ-038 WB_RR_EN defined, req_valid held at 5'b11111 with out_ready=1 -> grants in order 00001, 00010, 00100, 01000, 10000, 00001 (wrap).
REQ-039 WB_RR_EN undefined, req_valid=5'b10110 -> grant=00010 every cycle while bit 1 is held.
REQ-040 Output valid with out_ready=0 for 3 cycles -> payload stable, grant=0, stall_cnt increments by 3; out_ready=1 -> next winner appears one cycle later.
REQ-041 flush=1 while out_valid=1 and out_ready=0 -> next cycle out_valid=0, ptr unchanged, no grant during the flush cycle.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: default widths and the result payload type shared by the writeback arbiter.
package wb_pkg;
  localparam int WB_NUM_FU = 5;
  localparam int WB_DATA_W = 32;
  localparam int WB_ROB_W = 4;
  localparam int WB_DEST_W = 3;
  localparam int WB_CTRL_W = 6;
  typedef struct packed {
    logic [WB_DATA_W-1:0] data;
    logic [WB_ROB_W-1:0] rob;
    logic [WB_DEST_W-1:0] dest;
    logic [WB_CTRL_W-1:0] ctrl;
  } payload_t;
endpackage

// File: rtl/wb_if.sv
// wb_if: functional-unit request side and writeback output side of the arbiter.
interface wb_if #(
  parameter int NUM_FU = wb_pkg::WB_NUM_FU,
  parameter int DATA_WIDTH = wb_pkg::WB_DATA_W,
  parameter int ROB_SIZE = wb_pkg::WB_ROB_W,
  parameter int DEST_REG_SIZE = wb_pkg::WB_DEST_W,
  parameter int CTRL_WIDTH = wb_pkg::WB_CTRL_W
);
  logic [NUM_FU-1:0] req_valid;
  logic [NUM_FU*DATA_WIDTH-1:0] req_data;
  logic [NUM_FU*ROB_SIZE-1:0] req_rob;
  logic [NUM_FU*DEST_REG_SIZE-1:0] req_dest;
  logic [NUM_FU*CTRL_WIDTH-1:0] req_ctrl;
  logic flush;
  logic out_ready;
  logic [NUM_FU-1:0] grant;
  logic out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ROB_SIZE-1:0] out_rob;
  logic [DEST_REG_SIZE-1:0] out_dest;
  logic [CTRL_WIDTH-1:0] out_ctrl;
  logic out_nop;
  modport master (
    output req_valid, req_data, req_rob, req_dest, req_ctrl, flush, out_ready,
    input grant, out_valid, out_data, out_rob, out_dest, out_ctrl, out_nop
  );
  modport slave (
    input req_valid, req_data, req_rob, req_dest, req_ctrl, flush, out_ready,
    output grant, out_valid, out_data, out_rob, out_dest, out_ctrl, out_nop
  );
endinterface

// File: rtl/wb_rr_pick.sv
// wb_rr_pick: one-hot pick of the first set request at or above start, wrapping to index 0.
module wb_rr_pick #(
  parameter int N = 5,
  parameter int PW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] start,
  output logic [N-1:0]  grant
);
  logic [N-1:0] hi;
  always_comb begin
    hi = req & ({N{1'b1}} << start);
    grant = |hi ? hi & -hi : req & -req;
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: grants one functional-unit result per cycle into a registered writeback slot.
// Define WB_RR_EN for round-robin selection; otherwise the lowest requesting index wins.
module wb_arbiter import wb_pkg::*; #(
  parameter int NUM_FU = WB_NUM_FU,
  parameter int DATA_WIDTH = WB_DATA_W,
  parameter int ROB_SIZE = WB_ROB_W,
  parameter int DEST_REG_SIZE = WB_DEST_W,
  parameter int CTRL_WIDTH = WB_CTRL_W
) (
  input logic clk,
  input logic reset,
  wb_if.slave bus
);
  localparam int PW = NUM_FU > 1 ? $clog2(NUM_FU) : 1;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ROB_SIZE-1:0] rob;
    logic [DEST_REG_SIZE-1:0] dest;
    logic [CTRL_WIDTH-1:0] ctrl;
  } slot_t;
  logic [NUM_FU-1:0] pick, grant;
  logic free;
  logic [PW-1:0] ptr_d, ptr_q;
  logic out_valid_d, out_valid_q;
  slot_t sel, slot_d, slot_q;
  logic [15:0] stall_cnt_d, stall_cnt_q;
`ifdef WB_RR_EN
  logic [PW-1:0] nxt;
`endif
  wb_rr_pick #(.N(NUM_FU), .PW(PW)) u_pick (.req(bus.req_valid), .start(ptr_q), .grant(pick));
  always_comb begin
    free = (~out_valid_q | bus.out_ready) & ~bus.flush & ~reset;
    grant = free ? pick : '0;
    sel = '0;
    for (int i = 0; i < NUM_FU; i++)
      sel = grant[i] ? {bus.req_data[i*DATA_WIDTH +: DATA_WIDTH], bus.req_rob[i*ROB_SIZE +: ROB_SIZE],
                        bus.req_dest[i*DEST_REG_SIZE +: DEST_REG_SIZE], bus.req_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH]} : sel;
    // a held entry survives only while downstream stalls and nothing flushes it
    out_valid_d = |grant | (out_valid_q & ~bus.out_ready & ~bus.flush);
    slot_d = |grant ? sel : slot_q;
`ifdef WB_RR_EN
    nxt = '0;
    for (int i = 0; i < NUM_FU; i++)
      nxt = grant[i] ? PW'((i + 1) % NUM_FU) : nxt;
    ptr_d = |grant ? nxt : ptr_q;
`else
    ptr_d = '0;
`endif
    stall_cnt_d = (|bus.req_valid & ~|grant & ~&stall_cnt_q) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      slot_q <= '0;
      ptr_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      slot_q <= slot_d;
      ptr_q <= ptr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign bus.grant = grant;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data = slot_q.data;
  assign bus.out_rob = slot_q.rob;
  assign bus.out_dest = slot_q.dest;
  assign bus.out_ctrl = slot_q.ctrl;
  assign bus.out_nop = ~out_valid_q;
endmodule
